// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: frame constants,
// parser state encoding and a command-code check helper.
package uart_cmd_parser_pkg;

  localparam logic [7:0] HEAD     = 8'h55;
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam int         FRM_LEN  = 8;
  // Bytes between HEAD and CHK (CMD, ADDR_H/M/L, DATA_H/L).
  localparam int         BODY_LEN = FRM_LEN - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic logic is_cmd_ok(input logic [7:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer for UART-side framing logic.
// Counts enabled clocks since the last clear; flags the clock on which the
// count sits at TIMEOUT-1 with no clear present.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clr       : clear count (a byte arrived, or timing not active)
//   i_en        : count enable
//   o_timeout   : high while terminal count reached and not cleared this clk
module uart_gap_timer #(
  parameter int TIMEOUT = 52080
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int              CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TERM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A clear on the terminal clock wins over the timeout.
  assign o_timeout = i_en && !i_clr && (r_cnt == TERM);

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: assembles 8-byte frames
//   HEAD(0x55) CMD ADDR_H ADDR_M ADDR_L DATA_H DATA_L CHK
// from the UART receiver byte stream, validates the XOR checksum and command
// code, and presents one SDRAM read/write command over valid/ready.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_rx_vld/data   : received byte strobe and value
//   o_cmd_vld       : command pending; i_cmd_rdy completes the handshake
//   o_cmd_wr        : 1 = write, 0 = read
//   o_cmd_addr      : word address (low ADDR_W bits of ADDR_H/M/L)
//   o_cmd_wdata     : {DATA_H, DATA_L}
//   o_frm_err       : 1-clk pulse on bad checksum, bad command or gap timeout
//   o_drop_err      : 1-clk pulse when a byte arrives while a command is pending
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 52080
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rx_vld,
  input  logic [7:0]        i_rx_data,
  output logic              o_cmd_vld,
  input  logic              i_cmd_rdy,
  output logic              o_cmd_wr,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [DATA_W-1:0] o_cmd_wdata,
  output logic              o_frm_err,
  output logic              o_drop_err
);

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_idx;
  logic [7:0]          r_chk;
  logic [7:0]          r_cmd_byte;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_cmd_vld;
  logic                r_cmd_wr;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_wdata;
  logic                r_frm_err;
  logic                r_drop_err;

  logic w_timeout;
  logic w_store;
  logic w_load;
  logic w_frm_err_next;
  logic w_drop_err_next;

  uart_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (i_rx_vld || (r_state != ST_RECV)),
    .i_en      (r_state == ST_RECV),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_store         = 1'b0;
    w_load          = 1'b0;
    w_frm_err_next  = 1'b0;
    w_drop_err_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_vld && (i_rx_data == HEAD)) begin
          w_state_next = ST_RECV;
        end
      end
      ST_RECV: begin
        if (i_rx_vld) begin
          if (r_idx == 3'(BODY_LEN)) begin
            // This byte is CHK: accept only a matching checksum and known command.
            if ((r_chk == i_rx_data) && is_cmd_ok(r_cmd_byte)) begin
              w_load       = 1'b1;
              w_state_next = ST_OUT;
            end else begin
              w_frm_err_next = 1'b1;
              w_state_next   = ST_IDLE;
            end
          end else begin
            w_store = 1'b1;
          end
        end else if (w_timeout) begin
          w_frm_err_next = 1'b1;
          w_state_next   = ST_IDLE;
        end
      end
      ST_OUT: begin
        w_drop_err_next = i_rx_vld;
        if (r_cmd_vld && i_cmd_rdy) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Byte index, checksum accumulator and field capture. Fields are captured
  // directly by index so only the bits that reach the outputs are stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_chk      <= '0;
      r_cmd_byte <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else if (r_state != ST_RECV) begin
      r_idx <= '0;
      r_chk <= '0;
    end else if (w_store) begin
      r_idx <= r_idx + 1'b1;
      r_chk <= r_chk ^ i_rx_data;
      if (r_idx == 3'd0) begin
        r_cmd_byte <= i_rx_data;
      end else if (r_idx <= 3'd3) begin
        r_addr <= ADDR_W'({r_addr, i_rx_data});
      end else begin
        r_data <= DATA_W'({r_data, i_rx_data});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_vld   <= 1'b0;
      r_cmd_wr    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_frm_err   <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_frm_err  <= w_frm_err_next;
      r_drop_err <= w_drop_err_next;
      if (w_load) begin
        r_cmd_vld   <= 1'b1;
        r_cmd_wr    <= (r_cmd_byte == CMD_WR);
        r_cmd_addr  <= r_addr;
        r_cmd_wdata <= r_data;
      end else if (r_cmd_vld && i_cmd_rdy) begin
        r_cmd_vld <= 1'b0;
      end
    end
  end

  assign o_cmd_vld   = r_cmd_vld;
  assign o_cmd_wr    = r_cmd_wr;
  assign o_cmd_addr  = r_cmd_addr;
  assign o_cmd_wdata = r_cmd_wdata;
  assign o_frm_err   = r_frm_err;
  assign o_drop_err  = r_drop_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: a fixed vector table, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_uart_cmd_parser;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_vld = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_rdy = 1'b0;
  logic        cmd_vld;
  logic        cmd_wr;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        frm_err;
  logic        drop_err;

  uart_cmd_parser #(
    .ADDR_W  (22),
    .DATA_W  (16),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx_vld    (rx_vld),
    .i_rx_data   (rx_data),
    .o_cmd_vld   (cmd_vld),
    .i_cmd_rdy   (cmd_rdy),
    .o_cmd_wr    (cmd_wr),
    .o_cmd_addr  (cmd_addr),
    .o_cmd_wdata (cmd_wdata),
    .o_frm_err   (frm_err),
    .o_drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- frame-level reference model ----------------
  logic [7:0]  m_q[$];    // bytes of the frame being collected (HEAD first)
  int          m_gap;
  bit          m_pend;
  bit          m_wr;
  logic [21:0] m_addr;
  logic [15:0] m_wdata;
  bit          m_frm;
  bit          m_drop;

  task automatic model_reset();
    m_q.delete();
    m_gap = 0; m_pend = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    m_frm = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit vld, input logic [7:0] d, input bit rdy);
    logic [7:0]  x;
    logic [23:0] a;
    m_frm = 0; m_drop = 0;
    if (m_pend) begin
      if (vld) m_drop = 1;
      if (rdy) m_pend = 0;
    end else if (m_q.size() > 0) begin
      if (vld) begin
        m_q.push_back(d);
        m_gap = 0;
        if (m_q.size() == 8) begin
          x = 8'h00;
          for (int i = 1; i <= 6; i++) x = x ^ m_q[i];
          if (x == m_q[7] && (m_q[1] == 8'h01 || m_q[1] == 8'h02)) begin
            m_pend  = 1;
            m_wr    = (m_q[1] == 8'h01);
            a       = {m_q[2], m_q[3], m_q[4]};
            m_addr  = a[21:0];
            m_wdata = {m_q[5], m_q[6]};
          end else begin
            m_frm = 1;
          end
          m_q.delete();
        end
      end else begin
        m_gap++;
        if (m_gap == TO) begin
          m_frm = 1;
          m_q.delete();
        end
      end
    end else if (vld && d == 8'h55) begin
      m_q.push_back(d);
      m_gap = 0;
    end
  endtask

  task automatic check_model(input string tag);
    bit ok;
    n_vec++;
    ok = (cmd_vld == m_pend) && (frm_err == m_frm) && (drop_err == m_drop);
    if (m_pend) ok = ok && (cmd_wr == m_wr) && (cmd_addr == m_addr) && (cmd_wdata == m_wdata);
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got vld=%0b wr=%0b addr=%06h wd=%04h frm=%0b drop=%0b, want vld=%0b wr=%0b addr=%06h wd=%04h frm=%0b drop=%0b",
               tag, cmd_vld, cmd_wr, cmd_addr, cmd_wdata, frm_err, drop_err,
               m_pend, m_wr, m_addr, m_wdata, m_frm, m_drop);
    end
  endtask

  // One clock: drive at negedge, advance model, sample at next negedge.
  task automatic drive(input bit vld, input logic [7:0] d, input bit rdy, input string tag);
    rx_vld = vld; rx_data = d; cmd_rdy = rdy;
    model_step(vld, d, rdy);
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic send_frame(input logic [7:0] f[8], input bit rdy, input string tag);
    for (int i = 0; i < 8; i++) drive(1'b1, f[i], rdy, tag);
  endtask

  task automatic check_reset_vals(input string tag);
    n_vec++;
    if (cmd_vld !== 1'b0 || cmd_wr !== 1'b0 || cmd_addr !== 22'h0 || cmd_wdata !== 16'h0 ||
        frm_err !== 1'b0 || drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got vld=%0b wr=%0b addr=%06h wd=%04h frm=%0b drop=%0b, want all zero",
               tag, cmd_vld, cmd_wr, cmd_addr, cmd_wdata, frm_err, drop_err);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        e_vld;
    logic        e_wr;
    logic [21:0] e_addr;
    logic [15:0] e_wd;
    logic        e_frm;
    logic        e_drop;
  } vec_t;

  vec_t tab[$];

  function automatic void tv(logic vld, logic [7:0] d, logic rdy, logic ev, logic ew,
                             logic [21:0] ea, logic [15:0] ewd, logic ef, logic ed);
    vec_t v;
    v.vld = vld; v.d = d; v.rdy = rdy; v.e_vld = ev; v.e_wr = ew;
    v.e_addr = ea; v.e_wd = ewd; v.e_frm = ef; v.e_drop = ed;
    tab.push_back(v);
  endfunction

  function automatic void tv_body(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                  logic [7:0] b3, logic [7:0] b4, logic [7:0] b5, logic [7:0] b6);
    logic [7:0] bb[7];
    bb = '{b0, b1, b2, b3, b4, b5, b6};
    for (int i = 0; i < 7; i++) tv(1'b1, bb[i], 1'b1, 0, 0, 22'h0, 16'h0, 0, 0);
  endfunction

  logic [7:0] fr[8];
  int         gap;
  bit         ok;

  initial begin
    model_reset();
    // Good write, handshake on first cycle of cmd_vld.
    tv_body(8'h55, 8'h01, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD);
    tv(1, 8'h41, 1, 1, 1, 22'h001234, 16'hABCD, 0, 0);
    tv(0, 8'h00, 1, 0, 0, 22'h0, 16'h0, 0, 0);
    // Bad checksum.
    tv_body(8'h55, 8'h01, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD);
    tv(1, 8'h40, 1, 0, 0, 22'h0, 16'h0, 1, 0);
    tv(0, 8'h00, 1, 0, 0, 22'h0, 16'h0, 0, 0);
    // Unknown command with a consistent checksum.
    tv_body(8'h55, 8'h07, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD);
    tv(1, 8'h47, 1, 0, 0, 22'h0, 16'h0, 1, 0);
    tv(0, 8'h00, 1, 0, 0, 22'h0, 16'h0, 0, 0);
    // Junk in idle is ignored silently.
    tv(1, 8'hAA, 1, 0, 0, 22'h0, 16'h0, 0, 0);
    tv(1, 8'h01, 1, 0, 0, 22'h0, 16'h0, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tab[k]) begin
      rx_vld = tab[k].vld; rx_data = tab[k].d; cmd_rdy = tab[k].rdy;
      model_step(tab[k].vld, tab[k].d, tab[k].rdy);
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      ok = (cmd_vld == tab[k].e_vld) && (frm_err == tab[k].e_frm) && (drop_err == tab[k].e_drop);
      if (tab[k].e_vld)
        ok = ok && (cmd_wr == tab[k].e_wr) && (cmd_addr == tab[k].e_addr) && (cmd_wdata == tab[k].e_wd);
      if (!ok) begin
        n_err++;
        $display("FAIL table[%0d]: got vld=%0b wr=%0b addr=%06h wd=%04h frm=%0b drop=%0b, want vld=%0b wr=%0b addr=%06h wd=%04h frm=%0b drop=%0b",
                 k, cmd_vld, cmd_wr, cmd_addr, cmd_wdata, frm_err, drop_err,
                 tab[k].e_vld, tab[k].e_wr, tab[k].e_addr, tab[k].e_wd, tab[k].e_frm, tab[k].e_drop);
      end
    end

    // Read frame, cmd_rdy held low for 100 clocks then handshake.
    fr = '{8'h55, 8'h02, 8'h3F, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h3D};
    send_frame(fr, 1'b0, "read_frame");
    n_vec++;
    if (cmd_addr != 22'h3FFFFF || cmd_wr != 1'b0 || cmd_vld != 1'b1) begin
      n_err++;
      $display("FAIL read_fields: got vld=%0b wr=%0b addr=%06h, want vld=1 wr=0 addr=3fffff",
               cmd_vld, cmd_wr, cmd_addr);
    end
    repeat (100) drive(1'b0, 8'h00, 1'b0, "read_hold");
    drive(1'b0, 8'h00, 1'b1, "read_handshake");
    drive(1'b0, 8'h00, 1'b1, "read_after");

    // Gap timeout after 3 bytes; then TO-1 idle gap inside a good frame survives.
    drive(1'b1, 8'h55, 1'b0, "to_head");
    drive(1'b1, 8'h01, 1'b0, "to_cmd");
    drive(1'b1, 8'h00, 1'b0, "to_addr");
    repeat (TO + 2) drive(1'b0, 8'h00, 1'b0, "to_wait");
    fr = '{8'h55, 8'h01, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    for (int i = 0; i < 8; i++) begin
      if (i == 4) repeat (TO - 1) drive(1'b0, 8'h00, 1'b0, "gap_edge");
      drive(1'b1, fr[i], 1'b0, "post_to_frame");
    end
    // Bytes while pending are dropped, including HEAD and on the handshake clock.
    drive(1'b1, 8'h55, 1'b0, "drop_head");
    drive(1'b0, 8'h00, 1'b0, "drop_idle");
    drive(1'b1, 8'h12, 1'b1, "drop_on_hs");
    fr = '{8'h55, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h05};
    send_frame(fr, 1'b1, "after_drop");
    drive(1'b0, 8'h00, 1'b1, "after_drop_hs");

    // Reset in the middle of a frame.
    drive(1'b1, 8'h55, 1'b0, "rst_b0");
    drive(1'b1, 8'h01, 1'b0, "rst_b1");
    drive(1'b1, 8'h00, 1'b0, "rst_b2");
    drive(1'b1, 8'h12, 1'b0, "rst_b3");
    rx_vld = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid_frame_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h34, 1'b1, "post_rst_junk");
    drive(1'b1, 8'hAB, 1'b1, "post_rst_junk");
    drive(1'b1, 8'hCD, 1'b1, "post_rst_junk");
    drive(1'b1, 8'h41, 1'b1, "post_rst_junk");
    fr = '{8'h55, 8'h01, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_frame(fr, 1'b1, "post_rst_frame");
    drive(1'b0, 8'h00, 1'b1, "post_rst_hs");

    // Randomized frames, junk, gaps and back-pressure.
    for (int n = 0; n < 300; n++) begin
      fr[0] = 8'h55;
      fr[1] = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      for (int i = 2; i < 7; i++) fr[i] = 8'($urandom);
      fr[7] = 8'h00;
      for (int i = 1; i < 7; i++) fr[7] = fr[7] ^ fr[i];
      if ($urandom_range(0, 6) == 0) fr[7] = fr[7] ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) drive(1'b1, 8'($urandom), $urandom_range(0, 3) != 0, "rnd_junk");
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 29))
          0:       gap = TO;
          1:       gap = TO - 1;
          default: gap = $urandom_range(0, 3);
        endcase
        repeat (gap) drive(1'b0, 8'h00, $urandom_range(0, 3) != 0, "rnd_idle");
        drive(1'b1, fr[i], $urandom_range(0, 3) != 0, "rnd_byte");
      end
    end
    repeat (4) drive(1'b0, 8'h00, 1'b1, "rnd_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
